// File: rtl/window_gen_max9.sv
// window_gen_max9: streaming 3x3 window generator feeding the Max9 pooling stage.
// Pixels arrive one per valid cycle in raster order. Two line buffers hold the
// previous two lines, and a 3x3 shift array assembles the window that ends at
// the current pixel. A window is announced only at stride-aligned positions
// with a full 3x3 neighbourhood inside the current frame.
//
// Optional feature macro: SOF_SYNC_EN
//   defined   -> the sof port exists; valid_in=1 with sof=1 forces the pixel to (0,0)
//   undefined -> no sof port; counters free-run and resync only through rst
module window_gen_max9 #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int STRIDE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   data_in,
`ifdef SOF_SYNC_EN
    input  logic                sof,
`endif
    output logic                valid_out,
    output logic [9*DATA_W-1:0] win_out,
    output logic                frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Position actually assigned to the pixel on data_in this cycle.
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             restart;

    // Two line buffers: line_near holds row r-1, line_far holds row r-2.
    logic [DATA_W-1:0] line_near [IMG_W];
    logic [DATA_W-1:0] line_far  [IMG_W];

    // Column taps for the current pixel, top to bottom.
    logic [DATA_W-1:0] taps [3];

    // 3x3 window register array, index 3*i+j = row i, column j (j=2 newest).
    logic [DATA_W-1:0] win [9];

    logic row_ok;
    logic col_ok;
    logic emit;
    logic frame_end;

`ifdef SOF_SYNC_EN
    assign restart = sof;
`else
    assign restart = 1'b0;
`endif

    // A qualified start-of-frame overrides whatever position the counters hold.
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (restart) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // Read the two older pixels of this column; the bottom tap is the input.
    always_comb begin
        taps[0] = line_far[cur_col];
        taps[1] = line_near[cur_col];
        taps[2] = data_in;
    end

    // Emission needs a full 3x3 neighbourhood and stride alignment on both
    // axes; with STRIDE limited to 1 or 2, (x-2)%2 reduces to the LSB of x.
    always_comb begin
        row_ok    = (cur_row >= ROW_FIRST_WIN) && ((STRIDE == 1) || !cur_row[0]);
        col_ok    = (cur_col >= COL_FIRST_WIN) && ((STRIDE == 1) || !cur_col[0]);
        emit      = row_ok && col_ok;
        frame_end = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    // Line buffer storage is never reset; stale contents are only read at
    // rows that cannot emit, so they never reach win_out in a valid window.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line_far[cur_col]  <= line_near[cur_col];
            line_near[cur_col] <= data_in;
        end
    end

    // Raster position counters; column wraps into the next row, and the last
    // pixel of the frame wraps both back to the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                if (cur_row == ROW_LAST) begin
                    row <= '0;
                end else begin
                    row <= cur_row + 1'b1;
                end
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Shift the window one column left on every accepted pixel and load the
    // new column from the taps; idle cycles leave the window untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else if (valid_in) begin
            for (int i = 0; i < 3; i++) begin
                win[3*i]     <= win[3*i+1];
                win[3*i+1]   <= win[3*i+2];
                win[3*i+2]   <= taps[i];
            end
        end
    end

    // One-cycle pulses for a fresh window and for the final pixel of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && emit;
            frame_done <= valid_in && frame_end;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 9; g++) begin : g_pack
            assign win_out[g*DATA_W +: DATA_W] = win[g];
        end
    endgenerate

endmodule

// File: tb/tb_window_gen_max9.sv
// tb_window_gen_max9: self-checking bench for window_gen_max9.
// Two instances: 4x4 stride 1 and 5x5 stride 2. A frame-store reference model
// derives each expected window directly from pixel coordinates.
// Optional feature macro: SOF_SYNC_EN (enables the sof resync scenario).
module tb_window_gen_max9;

    localparam int DW = 16;
    localparam int VW = 9 * DW;
    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;

    logic          valid_a, valid_b;
    logic [DW-1:0] data_a, data_b;
    logic          sof_a, sof_b;
    logic          vout_a, vout_b;
    logic [VW-1:0] win_a, win_b;
    logic          done_a, done_b;

    always #5 clk = ~clk;

    window_gen_max9 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_a),
        .data_in    (data_a),
`ifdef SOF_SYNC_EN
        .sof        (sof_a),
`endif
        .valid_out  (vout_a),
        .win_out    (win_a),
        .frame_done (done_a)
    );

    window_gen_max9 #(.DATA_W(DW), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_b),
        .data_in    (data_b),
`ifdef SOF_SYNC_EN
        .sof        (sof_b),
`endif
        .valid_out  (vout_b),
        .win_out    (win_b),
        .frame_done (done_b)
    );

    // Bench state and reference model.
    int            n_checks = 0;
    int            n_fail   = 0;
    int            sel;
    int            mw, mh, ms;
    int            m_row, m_col;
    logic [DW-1:0] img [5][5];
    logic [DW-1:0] exp_win [9];
    bit            last_emit;
    int            dut_wins;
    int            dut_dones;

    task automatic checkOutput(input string tag, input vec_t obs, input vec_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t packWindow();
        vec_t v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[k*DW +: DW] = exp_win[k];
        end
        return v;
    endfunction

    task automatic selectDut(input int s);
        sel = s;
        if (s == 0) begin
            mw = 4; mh = 4; ms = 1;
        end else begin
            mw = 5; mh = 5; ms = 2;
        end
    endtask

    task automatic modelReset();
        m_row     = 0;
        m_col     = 0;
        last_emit = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_win[k] = '0;
        end
    endtask

    // One clock of stimulus on the selected instance, followed by checks.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit s);
        bit   exp_v;
        bit   exp_d;
        logic obs_v;
        logic obs_d;
        vec_t obs_w;
        exp_v = 1'b0;
        exp_d = 1'b0;
        @(negedge clk);
        valid_a = (sel == 0) ? v : 1'b0;
        valid_b = (sel == 1) ? v : 1'b0;
        data_a  = d;
        data_b  = d;
        sof_a   = (sel == 0) ? s : 1'b0;
        sof_b   = (sel == 1) ? s : 1'b0;
        if (v) begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2 && (m_row - 2) % ms == 0 && (m_col - 2) % ms == 0) begin
                exp_v = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        exp_win[3*i+j] = img[m_row-2+i][m_col-2+j];
                    end
                end
            end
            last_emit = exp_v;
            if (m_row == mh - 1 && m_col == mw - 1) begin
                exp_d = 1'b1;
            end
            m_col++;
            if (m_col == mw) begin
                m_col = 0;
                m_row++;
                if (m_row == mh) begin
                    m_row = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        obs_v = (sel == 0) ? vout_a : vout_b;
        obs_d = (sel == 0) ? done_a : done_b;
        obs_w = (sel == 0) ? win_a : win_b;
        if (obs_v === 1'b1) dut_wins++;
        if (obs_d === 1'b1) dut_dones++;
        checkOutput("valid_out", vec_t'(obs_v), vec_t'(exp_v));
        checkOutput("frame_done", vec_t'(obs_d), vec_t'(exp_d));
        if (exp_v) begin
            checkOutput("win_out", obs_w, packWindow());
        end else if (!v && last_emit) begin
            checkOutput("win_hold", obs_w, packWindow());
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        sof_a   = 1'b0;
        sof_b   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_valid", vec_t'((sel == 0) ? vout_a : vout_b), vec_t'(1'b0));
        checkOutput("rst_done", vec_t'((sel == 0) ? done_a : done_b), vec_t'(1'b0));
        checkOutput("rst_win", (sel == 0) ? win_a : win_b, vec_t'(0));
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic sendPixels(input int first, input int last, input int max_gap, input bit rnd_data);
        for (int p = first; p <= last; p++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, '0, 1'b0);
            end
            applyStimulus(1'b1, rnd_data ? DW'($urandom) : DW'(p), 1'b0);
        end
    endtask

    task automatic startTest(input int s);
        selectDut(s);
        doReset();
        dut_wins  = 0;
        dut_dones = 0;
    endtask

    initial begin
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        sof_a   = 1'b0;
        sof_b   = 1'b0;
        selectDut(0);
        modelReset();
        repeat (2) @(posedge clk);

        // Test 1: 4x4 stride 1, back-to-back frame.
        startTest(0);
        sendPixels(0, 15, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t1_win_count", vec_t'(dut_wins), vec_t'(4));
        checkOutput("t1_done_count", vec_t'(dut_dones), vec_t'(1));

        // Test 2: 5x5 stride 2.
        startTest(1);
        sendPixels(0, 24, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t2_win_count", vec_t'(dut_wins), vec_t'(4));
        checkOutput("t2_done_count", vec_t'(dut_dones), vec_t'(1));

        // Test 3: random idle gaps between pixels.
        startTest(0);
        sendPixels(0, 15, 3, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t3_win_count", vec_t'(dut_wins), vec_t'(4));
        checkOutput("t3_done_count", vec_t'(dut_dones), vec_t'(1));

        // Test 4: reset mid-frame after pixel 9, then a full frame.
        startTest(0);
        sendPixels(0, 9, 0, 1'b0);
        doReset();
        dut_wins  = 0;
        dut_dones = 0;
        sendPixels(0, 15, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4_win_count", vec_t'(dut_wins), vec_t'(4));
        checkOutput("t4_done_count", vec_t'(dut_dones), vec_t'(1));

        // Test 5: two frames back-to-back.
        startTest(0);
        sendPixels(0, 15, 0, 1'b0);
        sendPixels(0, 15, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t5_win_count", vec_t'(dut_wins), vec_t'(8));
        checkOutput("t5_done_count", vec_t'(dut_dones), vec_t'(2));

`ifdef SOF_SYNC_EN
        // Test 6: partial frame abandoned by sof.
        startTest(0);
        sendPixels(0, 5, 0, 1'b0);
        applyStimulus(1'b1, '0, 1'b1);
        sendPixels(1, 15, 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t6_win_count", vec_t'(dut_wins), vec_t'(4));
        checkOutput("t6_done_count", vec_t'(dut_dones), vec_t'(1));
`endif

        // Random data with random gaps on both geometries, several frames.
        for (int s = 0; s < 2; s++) begin
            startTest(s);
            for (int f = 0; f < 3; f++) begin
                sendPixels(0, mw * mh - 1, 2, 1'b1);
            end
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("rnd_win_count", vec_t'(dut_wins), vec_t'(12));
            checkOutput("rnd_done_count", vec_t'(dut_dones), vec_t'(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
